wishbone_arbiter: RTL
=====================

// Module: wishbone_arbiter
// PURPOSE
//  Round-robin arbiter letting NUM_CTRL Wishbone controllers share the single controller port of
//  the interconnect. Sits between the CPU/DMA-style controllers and the interconnect input.
//  Grants one controller per bus cycle (CYC high span) and routes its signals through; others wait.
// PARAMETERS
//  NUM_CTRL     2   number of requesting controllers (2..8)
//  ADR_W        16  address width; must cover the interconnect decode (adr[15:4] = peripheral)
//  TIMEOUT      255 watchdog limit in cycles (used only with WISHBONE_ARBITER_TIMEOUT_EN)
// PORTS
//  wb_clk       in   1            bus clock, all logic on rising edge
//  wb_rst       in   1            asynchronous, active-high reset
//  c_cyc        in   NUM_CTRL     per-controller CYC
//  c_stb        in   NUM_CTRL     per-controller STB
//  c_we         in   NUM_CTRL     per-controller WE
//  c_adr        in   NUM_CTRL*ADR_W  per-controller address, controller i at [i*ADR_W +: ADR_W]
//  c_sel        in   NUM_CTRL*4   per-controller byte select
//  c_dat_c      in   NUM_CTRL*32  per-controller write data
//  c_dat_p      out  32           read data, broadcast to all controllers (valid with own ack)
//  c_ack        out  NUM_CTRL     per-controller ACK
//  c_err        out  NUM_CTRL     per-controller ERR (timeout only; constant 0 without macro)
//  m_cyc, m_stb, m_we  out 1      to interconnect
//  m_adr        out  ADR_W        to interconnect
//  m_sel        out  4            to interconnect
//  m_dat_c      out  32           to interconnect
//  m_dat_p      in   32           from interconnect
//  m_ack        in   1            from interconnect
//  grant        out  NUM_CTRL     one-hot current owner (debug/status), 0 when IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, grant=0, last=NUM_CTRL-1 (controller 0 has top priority);
//   all m_* outputs, c_ack, c_err = 0 immediately, combinationally with reset.
//  FSM: IDLE -> BUSY at edge where any c_cyc=1; owner = first requester scanning from last+1
//   modulo NUM_CTRL (round-robin); grant registered, so grant latency = 1 cycle after c_cyc.
//  BUSY: m_* = owner's c_* (m_cyc = c_cyc[owner]); c_ack[owner]=m_ack, others 0;
//   c_dat_p = m_dat_p. Non-owners are held: their CYC/STB ignored, never acked.
//  BUSY -> IDLE at edge where c_cyc[owner]=0; last<=owner. One idle cycle between owners
//   (m_cyc=0 that cycle) guarantees interconnect address persistence is refreshed.
//  Owner holds bus for whole CYC span incl. multiple STB/ACK beats (locked block transfers).
//  Simultaneous requests: round-robin order only; equal-priority starvation impossible since
//   each owner becomes lowest priority after release.
//  Owner drops CYC same cycle as m_ack: ack is delivered, release takes effect at that edge.
//  Request dropped before grant: no bus cycle issued; IDLE scan re-evaluates every cycle.
//  Reset mid-transfer: bus released instantly; controllers must restart their cycle.
//  In IDLE all m_* = 0; m_ack arriving in IDLE is discarded.
// CONFIGURATION
//  WISHBONE_ARBITER_TIMEOUT_EN defined: counter (clog2(TIMEOUT+1) bits) clears on grant and on
//   every m_ack, increments each BUSY cycle with m_stb=1 and m_ack=0; on reaching TIMEOUT:
//   c_err[owner] pulses 1 cycle, m_cyc forced 0 that cycle, FSM -> IDLE, last<=owner.
//  Not defined: no counter, c_err tied 0, owner may hold bus indefinitely.
// TESTING
//  1 Reset: wb_rst=1 with c_cyc=2'b11 -> grant=0, m_cyc=0, c_ack=0; release -> next edge grant=2'b01.
//  2 Single read: ctrl1 cyc/stb adr=16'h0010; slave acks dat 32'hCAFE0001 after 2 cycles ->
//    m_adr=16'h0010, c_ack=2'b10 for 1 cycle, c_dat_p=32'hCAFE0001, ctrl0 never acked.
//  3 Round-robin: both hold cyc continuously, each releases after 1 beat -> grants 01,idle,10,idle,01.
//  4 Locked burst: ctrl0 4 beats adr 0x20..0x23 within one CYC while ctrl1 requests ->
//    ctrl1 granted only after ctrl0 drops cyc; m_adr sequence exact, 4 acks to ctrl0.
//  5 Async reset mid-beat (BUSY, ack pending) -> m_cyc=0 same cycle without clock edge; grant=0.
//  6 TIMEOUT_EN, TIMEOUT=8: slave never acks -> c_err[owner]=1 exactly 8 cycles after stb,
//    then IDLE; without macro bus stays granted 100+ cycles, c_err=0.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter multiplexing NUM_CTRL Wishbone controllers onto one interconnect port.
// Optional bus watchdog enabled by defining WISHBONE_ARBITER_TIMEOUT_EN.
module wishbone_arbiter #(
  parameter int unsigned NUM_CTRL = 2,
  parameter int unsigned ADR_W    = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [NUM_CTRL-1:0]       c_cyc,
  input  logic [NUM_CTRL-1:0]       c_stb,
  input  logic [NUM_CTRL-1:0]       c_we,
  input  logic [NUM_CTRL*ADR_W-1:0] c_adr,
  input  logic [NUM_CTRL*4-1:0]     c_sel,
  input  logic [NUM_CTRL*32-1:0]    c_dat_c,
  output logic [31:0]               c_dat_p,
  output logic [NUM_CTRL-1:0]       c_ack,
  output logic [NUM_CTRL-1:0]       c_err,
  output logic                      m_cyc,
  output logic                      m_stb,
  output logic                      m_we,
  output logic [ADR_W-1:0]          m_adr,
  output logic [3:0]                m_sel,
  output logic [31:0]               m_dat_c,
  input  logic [31:0]               m_dat_p,
  input  logic                      m_ack,
  output logic [NUM_CTRL-1:0]       grant
);

  localparam int unsigned IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_CTRL-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    pick;
  logic                pick_vld;
  logic                busy;
  logic                to_hit;

  // Gated by reset so the bus drops the instant reset asserts.
  assign busy    = (state_q == S_BUSY) && !wb_rst;
  assign grant   = grant_q;
  assign c_dat_p = m_dat_p;

  // Round-robin scan starting just after the most recent owner.
  always_comb begin : rr_pick
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_CTRL; k++) begin
      idx = (32'(last_q) + k) % NUM_CTRL;
      if (!pick_vld && c_cyc[IDX_W'(idx)]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef WISHBONE_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign to_hit = busy && (cnt_q == CNT_W'(TIMEOUT));

  // Counts stalled strobe cycles of the current owner; any ack restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE || m_ack) begin
      cnt_d = '0;
    end else if (c_stb[owner_q] && cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_BUSY;
          owner_d = pick;
          grant_d = NUM_CTRL'(1) << pick;
        end
      end
      S_BUSY: begin
        // Owner becomes lowest priority once it lets go (or is evicted).
        if (!c_cyc[owner_q] || to_hit) begin
          state_d = S_IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_CTRL - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Owner's signals routed through; everything held at zero otherwise.
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_sel   = '0;
    m_dat_c = '0;
    c_ack   = '0;
    c_err   = '0;
    if (busy) begin
      m_cyc          = c_cyc[owner_q] && !to_hit;
      m_stb          = c_stb[owner_q] && !to_hit;
      m_we           = c_we[owner_q];
      m_adr          = c_adr[32'(owner_q)*ADR_W +: ADR_W];
      m_sel          = c_sel[32'(owner_q)*4 +: 4];
      m_dat_c        = c_dat_c[32'(owner_q)*32 +: 32];
      c_ack[owner_q] = m_ack && !to_hit;
      c_err[owner_q] = to_hit;
    end
  end

endmodule
